// File: rtl/iir_inverse_fir.sv
// Inverse (equalizing) FIR for the all-pole IIR path: x[n] = y[n] + sum_k a_k*y[n-k].
// Optional build macro ROUND_EN selects round-half-up scaling instead of floor.
module iir_inverse_fir #(
   parameter int unsigned DW    = 8,
   parameter int unsigned CW    = 8,
   parameter int unsigned CFRAC = 6,
   parameter int unsigned TAPS  = 4,
   localparam int unsigned AIW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] din,
   input  logic                 coef_we,
   input  logic [AIW-1:0]       coef_addr,
   input  logic signed [CW-1:0] coef_wdata,
   output logic                 out_valid,
   output logic signed [DW-1:0] dout,
   output logic                 sat_flag
);

   localparam int unsigned PW = DW + CW;
   localparam int unsigned AW = DW + CW + $clog2(TAPS + 1);
`ifdef ROUND_EN
   localparam int unsigned RND_ADD = 1 << (CFRAC - 1);
`else
   localparam int unsigned RND_ADD = 0;
`endif
   localparam logic signed [AW-1:0] SMAX = AW'((1 << (DW - 1)) - 1);
   localparam logic signed [AW-1:0] SMIN = ~SMAX;

   logic signed [CW-1:0] coef_q [TAPS];
   logic signed [DW-1:0] hist_q [TAPS];
   logic signed [PW-1:0] term_q [TAPS+1];
   logic signed [PW-1:0] term_d [TAPS+1];
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] rnd_c, scaled_c;
   logic signed [DW-1:0] dout_q, dout_d;
   logic                 sat_q, sat_d;
   logic                 v1_q, v2_q, ov_q;

   // Stage-1 terms: scaled current sample plus one product per history tap
   always_comb begin
      term_d[0] = PW'(din) <<< CFRAC;
      for (int k = 0; k < int'(TAPS); k++) begin
         term_d[k+1] = PW'(coef_q[k]) * PW'(hist_q[k]);
      end
   end

   always_comb begin
      acc_d = '0;
      for (int k = 0; k <= int'(TAPS); k++) begin
         acc_d = acc_d + AW'(term_q[k]);
      end
   end

   // Scale back to sample units and clip to the output range
   always_comb begin
      rnd_c    = acc_q + $signed(AW'(RND_ADD));
      scaled_c = rnd_c >>> CFRAC;
      dout_d   = scaled_c[DW-1:0];
      sat_d    = 1'b0;
      if (scaled_c > SMAX) begin
         dout_d = SMAX[DW-1:0];
         sat_d  = 1'b1;
      end else if (scaled_c < SMIN) begin
         dout_d = SMIN[DW-1:0];
         sat_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(TAPS); k++) begin
            coef_q[k] <= '0;
            hist_q[k] <= '0;
         end
         for (int k = 0; k <= int'(TAPS); k++) begin
            term_q[k] <= '0;
         end
         acc_q  <= '0;
         dout_q <= '0;
         sat_q  <= 1'b0;
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         // Products use the coefficient value held before any same-edge write
         if (in_valid) begin
            for (int k = 0; k <= int'(TAPS); k++) begin
               term_q[k] <= term_d[k];
            end
            hist_q[0] <= din;
            for (int k = 1; k < int'(TAPS); k++) begin
               hist_q[k] <= hist_q[k-1];
            end
         end
         if (coef_we && (32'(coef_addr) < TAPS)) begin
            coef_q[coef_addr] <= coef_wdata;
         end
         v1_q <= in_valid;
         v2_q <= v1_q;
         ov_q <= v2_q;
         if (v1_q) begin
            acc_q <= acc_d;
         end
         if (v2_q) begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
         end
      end
   end

   assign out_valid = ov_q;
   assign dout      = dout_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_inverse_fir.sv
// Self-checking bench for iir_inverse_fir: arithmetic reference model plus directed literal checks.
module tb_iir_inverse_fir;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic signed [7:0] din;
   logic              coef_we;
   logic [1:0]        coef_addr;
   logic signed [7:0] coef_wdata;
   logic              out_valid;
   logic signed [7:0] dout;
   logic              sat_flag;

   iir_inverse_fir dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .din        (din),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .out_valid  (out_valid),
      .dout       (dout),
      .sat_flag   (sat_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int d;
      int s;
   } exp_t;

   int   vectors = 0;
   int   errors  = 0;
   int   cyc     = 0;
   bit   chk_en  = 1'b0;
   int   mcoef [4];
   int   mhist [4];
   exp_t pend [$];
   int   exp_d = 0;
   int   exp_s = 0;
   int   got_d [$];
   int   got_s [$];

   task automatic chk(input string nm, input int act, input int expv);
      vectors++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Reference: x = y + sum a_k*y[n-k] in Q1.6, then scale and clip
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         chk_en = 1'b1;
         for (int k = 0; k < 4; k++) begin
            mcoef[k] = 0;
            mhist[k] = 0;
         end
         pend.delete();
         exp_d = 0;
         exp_s = 0;
      end else begin
         if (in_valid) begin
            int   acc;
            int   q;
            exp_t e;
            acc = int'(din) * 64;
            for (int k = 0; k < 4; k++) acc += mcoef[k] * mhist[k];
`ifdef ROUND_EN
            acc += 32;
`endif
            q = acc >>> 6;
            e.due = cyc + 2;
            e.d   = (q > 127) ? 127 : (q < -128) ? -128 : q;
            e.s   = (q > 127 || q < -128) ? 1 : 0;
            pend.push_back(e);
            for (int k = 3; k > 0; k--) mhist[k] = mhist[k-1];
            mhist[0] = int'(din);
         end
         if (coef_we) mcoef[coef_addr] = int'(coef_wdata);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int ev;
         ev = 0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_t e;
            e     = pend.pop_front();
            exp_d = e.d;
            exp_s = e.s;
            ev    = 1;
         end
         chk("out_valid", int'(out_valid), ev);
         chk("dout", int'(dout), exp_d);
         chk("sat_flag", int'(sat_flag), exp_s);
         if (out_valid) begin
            got_d.push_back(int'(dout));
            got_s.push_back(int'(sat_flag));
         end
      end
   end

   task automatic drive(input bit v, input int d, input bit we, input int a, input int c);
      @(negedge clk);
      in_valid   = v;
      din        = 8'(d);
      coef_we    = we;
      coef_addr  = 2'(a);
      coef_wdata = 8'(c);
   endtask

   task automatic put(input int d);
      drive(1'b1, d, 1'b0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 0);
   endtask

   task automatic wcoef(input int a, input int c);
      drive(1'b0, 0, 1'b1, a, c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic clr();
      got_d.delete();
      got_s.delete();
   endtask

   task automatic exp_out(input string nm, input int idx, input int d, input int s);
      chk({nm, "_dout"}, (got_d.size() > idx) ? got_d[idx] : 9999, d);
      chk({nm, "_sat"},  (got_s.size() > idx) ? got_s[idx] : 9999, s);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; din = '0;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_dout", int'(dout), 0);
      chk("reset_sat", int'(sat_flag), 0);

      // pass-through with zero coefficients, back-to-back
      do_reset(); clr();
      put(5); put(-3); put(127); put(-128); idle(5);
      chk("t1_count", got_d.size(), 4);
      exp_out("t1_0", 0, 5, 0);  exp_out("t1_1", 1, -3, 0);
      exp_out("t1_2", 2, 127, 0); exp_out("t1_3", 3, -128, 0);

      do_reset(); wcoef(0, 32); clr();
      put(64); put(0); idle(5);
      exp_out("t2_0", 0, 64, 0); exp_out("t2_1", 1, 32, 0);

      // positive and negative saturation
      do_reset(); wcoef(0, 127); clr();
      put(127); put(127); put(-128); put(-128); idle(5);
      exp_out("t3_0", 0, 127, 0); exp_out("t3_1", 1, 127, 1);
      exp_out("t3_2", 2, 124, 0); exp_out("t3_3", 3, -128, 1);

      // gaps hold history
      do_reset(); wcoef(0, 64); clr();
      put(10); idle(2); put(20); idle(5);
      chk("t4_count", got_d.size(), 2);
      exp_out("t4_0", 0, 10, 0); exp_out("t4_1", 1, 30, 0);

      // reset discards in-flight samples and clears history/coefs
      do_reset(); wcoef(0, 64); clr();
      put(10); put(20); do_reset(); idle(4);
      chk("t5_none", got_d.size(), 0);
      chk("t5_dout", int'(dout), 0);
      put(7); idle(5);
      exp_out("t5_0", 0, 7, 0);

      // rounding boundary: 2080/64 = 32.5
      do_reset(); wcoef(0, 1); clr();
      put(32); put(32); idle(5);
      exp_out("t6_0", 0, 32, 0);
`ifdef ROUND_EN
      exp_out("t6_1", 1, 33, 0);
`else
      exp_out("t6_1", 1, 32, 0);
`endif

      // same-cycle coefficient write uses the old value
      do_reset(); clr();
      drive(1'b1, 10, 1'b1, 0, 64); put(20); idle(5);
      exp_out("t7_0", 0, 10, 0); exp_out("t7_1", 1, 30, 0);

      // deepest tap, negative coefficient
      do_reset(); wcoef(3, -64); clr();
      put(1); put(2); put(3); put(4); put(5); idle(5);
      exp_out("t8_3", 3, 4, 0); exp_out("t8_4", 4, 4, 0);

      // mixed taps with negative results to exercise floor toward -inf
      do_reset(); wcoef(0, -45); wcoef(1, 23); wcoef(2, 7); wcoef(3, -90); clr();
      put(-3); put(50); put(-77); put(1); put(-1); idle(1); put(99); put(-100); idle(6);
      chk("t9_count", got_d.size(), 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
